// File: rtl/pulse_interval_meter.sv
// Measures clk-cycle intervals between rising edges of pulse_in, with range check and timeout.
// Optional input synchronizer: define PULSE_INTERVAL_METER_SYNC_EN.
module pulse_interval_meter #(
   parameter int  CLK_FREQ       = 100_000_000,
   parameter real EXP_PERIOD     = 0.015,
   parameter int  TOL_CYCLES     = 1000,
   parameter real TIMEOUT_PERIOD = 0.030,
   parameter int  CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             in_range,
   output logic             timeout,
   output logic             busy
);

   localparam int EXP_CYC = $rtoi(EXP_PERIOD * CLK_FREQ);
   localparam int TO_CYC  = $rtoi(TIMEOUT_PERIOD * CLK_FREQ);

   // Bounds carry one extra bit so EXP_CYC + TOL_CYCLES cannot overflow.
   localparam logic [CNT_W:0] LO_BOUND = (EXP_CYC > TOL_CYCLES) ?
                                         (CNT_W+1)'(EXP_CYC - TOL_CYCLES) : '0;
   localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(EXP_CYC) + (CNT_W+1)'(TOL_CYCLES);
   localparam logic [CNT_W-1:0] TO_BOUND = CNT_W'(TO_CYC);

   if (longint'(TO_CYC) >= (64'sd1 <<< CNT_W)) begin : g_to_width_check
      $error("TO_CYC does not fit in CNT_W bits");
   end
   if (TO_CYC <= EXP_CYC) begin : g_to_order_check
      $error("TO_CYC must exceed EXP_CYC");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0] period_nxt_s;
   logic             valid_nxt_s;
   logic             in_range_nxt_s;
   logic             timeout_nxt_s;
   logic             pulse_s;
   logic             pulse_d_r;
   logic             edge_s;
   logic [CNT_W:0]   cnt_ext_s;

`ifdef PULSE_INTERVAL_METER_SYNC_EN
   logic sync1_r;
   logic sync2_r;

   // Two-flop synchronizer for an input asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= pulse_in;
         sync2_r <= sync1_r;
      end
   end

   assign pulse_s = sync2_r;
`else
   assign pulse_s = pulse_in;
`endif

   assign edge_s    = pulse_s & ~pulse_d_r;
   assign cnt_ext_s = {1'b0, cnt_r};

   // Next-state and next-output logic.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      period_nxt_s   = period;
      valid_nxt_s    = 1'b0;
      in_range_nxt_s = in_range;
      timeout_nxt_s  = timeout;
      case (state_r)
         ST_IDLE: begin
            if (edge_s) begin
               state_nxt_s = ST_MEASURE;
               cnt_nxt_s   = CNT_W'(1);
            end else begin
               cnt_nxt_s   = cnt_r;
            end
         end
         ST_MEASURE: begin
            // An edge landing on the timeout cycle still counts as a measurement.
            if (edge_s) begin
               period_nxt_s   = cnt_r;
               valid_nxt_s    = 1'b1;
               in_range_nxt_s = (cnt_ext_s >= LO_BOUND) && (cnt_ext_s <= HI_BOUND);
               cnt_nxt_s      = CNT_W'(1);
            end else if (cnt_r == TO_BOUND) begin
               state_nxt_s    = ST_TIMEOUT;
               timeout_nxt_s  = 1'b1;
            end else begin
               cnt_nxt_s      = cnt_r + CNT_W'(1);
            end
         end
         ST_TIMEOUT: begin
            if (edge_s) begin
               state_nxt_s   = ST_MEASURE;
               cnt_nxt_s     = CNT_W'(1);
               timeout_nxt_s = 1'b0;
            end else begin
               timeout_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = '0;
            timeout_nxt_s = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         pulse_d_r    <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         in_range     <= 1'b0;
         timeout      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         pulse_d_r    <= pulse_s;
         period       <= period_nxt_s;
         period_valid <= valid_nxt_s;
         in_range     <= in_range_nxt_s;
         timeout      <= timeout_nxt_s;
         busy         <= (state_nxt_s == ST_MEASURE);
      end
   end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Randomized self-checking bench for pulse_interval_meter against an edge-timestamp model.
// Build with PULSE_INTERVAL_METER_SYNC_EN to exercise the synchronizer variant.
module tb_pulse_interval_meter;

   localparam int EXP_C = 15;
   localparam int TOL_C = 1;
   localparam int TO_C  = 30;
`ifdef PULSE_INTERVAL_METER_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif

   logic        clk;
   logic        rst_n;
   logic        pulse_in;
   logic [31:0] period;
   logic        period_valid;
   logic        in_range;
   logic        timeout;
   logic        busy;

   pulse_interval_meter #(
      .CLK_FREQ(1000), .EXP_PERIOD(0.015), .TOL_CYCLES(1),
      .TIMEOUT_PERIOD(0.030), .CNT_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .period(period),
      .period_valid(period_valid), .in_range(in_range), .timeout(timeout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: timestamps of effective rising edges.
   int   cyc;
   int   last_edge;
   bit   have_ref;
   bit   prev_lvl;
   bit   dly0, dly1;
   logic        exp_valid, exp_timeout, exp_busy, exp_inr;
   logic [31:0] exp_period;
   int   skew_ns = 0;
   bit   stim[$];

   task automatic model_reset();
      cyc = 0; last_edge = 0; have_ref = 1'b0; prev_lvl = 1'b0;
      dly0 = 1'b0; dly1 = 1'b0;
      exp_valid = 1'b0; exp_timeout = 1'b0; exp_busy = 1'b0;
      exp_inr = 1'b0; exp_period = 32'd0;
   endtask

   function automatic logic [35:0] obs();
      return {period_valid, timeout, busy, in_range, period};
   endfunction

   function automatic logic [35:0] expv();
      return {exp_valid, exp_timeout, exp_busy, exp_inr, exp_period};
   endfunction

   // Drive one cycle of pulse_in and advance the model to the state after that clock edge.
   task automatic tick(input bit lvl);
      bit eff;
      bit edge_seen;
      if (skew_ns != 0) #(skew_ns);
      else @(negedge clk);
      pulse_in = lvl;
      @(posedge clk);
      eff = (SD == 2) ? dly1 : lvl;
      dly1 = dly0;
      dly0 = lvl;
      edge_seen = eff & ~prev_lvl;
      prev_lvl = eff;
      cyc++;
      exp_valid = 1'b0;
      if (edge_seen) begin
         if (have_ref && (cyc - last_edge) <= TO_C) begin
            exp_valid  = 1'b1;
            exp_period = 32'(cyc - last_edge);
            exp_inr    = (cyc - last_edge >= EXP_C - TOL_C) && (cyc - last_edge <= EXP_C + TOL_C);
         end
         last_edge = cyc;
         have_ref  = 1'b1;
      end
      exp_timeout = have_ref && (cyc - last_edge >= TO_C);
      exp_busy    = have_ref && !exp_timeout;
      #1;
   endtask

   task automatic add_pulse(input int gap, input int width);
      for (int i = 0; i < gap; i++) stim.push_back(i < width);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pulse_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 36'd0) begin
         errors++; $display("FAIL reset got=%h want=%h", obs(), 36'd0);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      add_pulse(6, 0);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL idle cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
   endtask

   task automatic test_nominal();
      int strobes = 0;
      for (int i = 0; i < 4; i++) add_pulse(15, 1);
      add_pulse(5, 0);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         if (period_valid === 1'b1) strobes++;
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
      checks++;
      if (strobes != 3) begin
         errors++; $display("FAIL nominal_strobes got=%0d want=3", strobes);
      end
   endtask

   task automatic test_tolerance();
      add_pulse(13, 1); add_pulse(14, 1); add_pulse(16, 2); add_pulse(17, 3); add_pulse(4, 1);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL tolerance cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
   endtask

   task automatic test_timeout();
      add_pulse(41, 1); add_pulse(15, 1); add_pulse(15, 1); add_pulse(3, 0);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL timeout cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
   endtask

   task automatic test_boundary();
      add_pulse(30, 1); add_pulse(31, 1); add_pulse(2, 1); add_pulse(2, 1);
      add_pulse(20, 12); add_pulse(20, 19); add_pulse(3, 1);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL boundary cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
   endtask

   task automatic test_reset_mid();
      add_pulse(15, 1); add_pulse(8, 0);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
      #2 rst_n = 1'b0; pulse_in = 1'b0;
      #1;
      checks++;
      if (obs() !== 36'd0) begin
         errors++; $display("FAIL async_reset got=%h want=%h", obs(), 36'd0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      add_pulse(15, 1); add_pulse(15, 1); add_pulse(5, 0);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
   endtask

   task automatic test_skewed();
      skew_ns = 3;
      for (int i = 0; i < 4; i++) add_pulse(15, 5);
      add_pulse(6, 0);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL skewed cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
      skew_ns = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         int gap;
         gap = $urandom_range(36, 2);
         add_pulse(gap, $urandom_range(gap - 1, 1));
      end
      add_pulse(4, 0);
      while (stim.size() > 0) begin
         tick(stim.pop_front());
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_tolerance();
      test_timeout();
      test_boundary();
      test_reset_mid();
      test_skewed();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
